// File: rtl/key_sched_pkg.sv
// Shared types and defaults for the key schedule feeder: FSM states, default
// slot count/width and the step counter width helper.
package key_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    RUN   = 2'd3
  } sched_state_t;

  localparam int DEF_NUM_KEYS = 4;
  localparam int DEF_KEY_W    = 3;

  // A single-slot schedule still needs a 1-bit step port.
  function automatic int step_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Serial shadow key register, right-shifting with the new bit entering at the MSB,
// plus a saturating bit counter; 1-cycle update per shift, no backpressure.
module key_shift_reg
  import key_sched_pkg::*;
#(
  parameter int DATA_W = DEF_NUM_KEYS * DEF_KEY_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shift,
  input  logic              restart,
  input  logic              sin,
  output logic [DATA_W-1:0] data,
  output logic              full
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0] cnt;

  // restart marks the first bit of a fresh load, so it counts as bit one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data <= '0;
      cnt  <= '0;
    end else if (shift) begin
      data <= {sin, data[DATA_W-1:1]};
      if (restart) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_W'(DATA_W)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign full = (cnt == CNT_W'(DATA_W));

endmodule

// File: rtl/key_sched_feeder.sv
// Loads a serial key image, commits it and steps slots out to a locked core; keyinput is
// combinational from registers, no backpressure. Macro KEY_SCHED_PARITY_EN adds trailing even parity and key_err.
module key_sched_feeder
  import key_sched_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int KEY_W    = DEF_KEY_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        key_sin,
  input  logic                        key_load,
  input  logic                        key_commit,
  input  logic                        run,
  output logic [KEY_W-1:0]            keyinput,
  output logic                        key_valid,
  output logic [step_w(NUM_KEYS)-1:0] step,
  output logic                        load_full
`ifdef KEY_SCHED_PARITY_EN
  ,
  output logic                        key_err
`endif
);

  localparam int STEP_W = step_w(NUM_KEYS);
  localparam int KEYS_W = NUM_KEYS * KEY_W;
`ifdef KEY_SCHED_PARITY_EN
  localparam int SHIFT_W = KEYS_W + 1;
`else
  localparam int SHIFT_W = KEYS_W;
`endif

  sched_state_t        state;
  sched_state_t        state_nxt;
  logic [SHIFT_W-1:0]  shadow;
  logic [KEYS_W-1:0]   active;
  logic                restart;
  logic                commit_req;
  logic                commit_ok;
  logic                parity_ok;

  assign restart = key_load && (state != LOAD);

  key_shift_reg #(
    .DATA_W (SHIFT_W)
  ) u_shift (
    .clock   (clock),
    .reset   (reset),
    .shift   (key_load),
    .restart (restart),
    .sin     (key_sin),
    .data    (shadow),
    .full    (load_full)
  );

  // Commits are only meaningful while loading; a concurrent key_load always wins.
  assign commit_req = key_commit && !key_load && load_full && (state == LOAD);

`ifdef KEY_SCHED_PARITY_EN
  assign parity_ok = ~^shadow;
`else
  assign parity_ok = 1'b1;
`endif

  assign commit_ok = commit_req && parity_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_valid = 1'b0;
    case (state)
      IDLE:  state_nxt = IDLE;
      LOAD:  if (commit_ok) state_nxt = READY;
      READY: begin
        key_valid = 1'b1;
        if (run) state_nxt = RUN;
      end
      RUN:   key_valid = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (key_load) begin
      state_nxt = LOAD;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step <= '0;
    end else if (key_load || commit_ok) begin
      step <= '0;
    end else if ((state == RUN) && run) begin
      step <= (step == STEP_W'(NUM_KEYS - 1)) ? '0 : step + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active <= '0;
    end else if (commit_ok) begin
      active <= shadow[KEYS_W-1:0];
    end
  end

`ifdef KEY_SCHED_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_err <= 1'b0;
    end else if (commit_req && !parity_ok) begin
      key_err <= 1'b1;
    end
  end
`endif

  always_comb begin
    keyinput = '0;
    if (key_valid) begin
      keyinput = active[step*KEY_W +: KEY_W];
    end
  end

endmodule

// File: tb/tb_key_sched_feeder.sv
// Randomized and directed bench for key_sched_feeder against a bit-queue reference model.
// Honours KEY_SCHED_PARITY_EN when defined.
module tb_key_sched_feeder;

  localparam int NK = 4;
  localparam int KW = 3;
  localparam int KB = NK * KW;
`ifdef KEY_SCHED_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = KB + PAR;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;
  localparam int M_RUN   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          key_sin = 1'b0;
  logic          key_load = 1'b0;
  logic          key_commit = 1'b0;
  logic          run = 1'b0;
  logic [KW-1:0] keyinput;
  logic          key_valid;
  logic [1:0]    step;
  logic          load_full;
`ifdef KEY_SCHED_PARITY_EN
  logic          key_err;
`endif

  key_sched_feeder #(
    .NUM_KEYS (NK),
    .KEY_W    (KW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_sin    (key_sin),
    .key_load   (key_load),
    .key_commit (key_commit),
    .run        (run),
    .keyinput   (keyinput),
    .key_valid  (key_valid),
    .step       (step),
    .load_full  (load_full)
`ifdef KEY_SCHED_PARITY_EN
    ,
    .key_err    (key_err)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode of operation, last NB bits seen (oldest first),
  // bits counted since the current load began, committed slot values.
  int m_mode;
  int m_cnt;
  int m_step;
  bit m_err;
  int m_slot[NK];
  bit hist[$];

  function automatic void m_reset();
    m_mode = M_IDLE;
    m_cnt  = 0;
    m_step = 0;
    m_err  = 1'b0;
    for (int k = 0; k < NK; k++) m_slot[k] = 0;
    hist.delete();
    for (int i = 0; i < NB; i++) hist.push_back(1'b0);
  endfunction

  function automatic void m_clock(input bit l, input bit s, input bit c, input bit r);
    bit par;
    if (l) begin
      if (m_mode != M_LOAD) m_cnt = 1;
      else if (m_cnt < NB) m_cnt++;
      hist.push_back(s);
      void'(hist.pop_front());
      m_mode = M_LOAD;
      m_step = 0;
    end else if (c && m_mode == M_LOAD && m_cnt == NB) begin
      par = 1'b0;
      for (int i = 0; i < NB; i++) par ^= hist[i];
      if (PAR == 1 && par) begin
        m_err = 1'b1;
      end else begin
        for (int k = 0; k < NK; k++) begin
          m_slot[k] = 0;
          for (int j = 0; j < KW; j++) m_slot[k] += int'(hist[k*KW + j]) << j;
        end
        m_mode = M_READY;
        m_step = 0;
      end
    end else if (r && m_mode == M_READY) begin
      m_mode = M_RUN;
    end else if (r && m_mode == M_RUN) begin
      m_step = (m_step + 1) % NK;
    end
  endfunction

  task automatic check_outputs();
    int exp_ki;
    exp_ki = (m_mode >= M_READY) ? m_slot[m_step] : 0;
    chk("keyinput", keyinput, exp_ki);
    chk("key_valid", key_valid, (m_mode >= M_READY) ? 1 : 0);
    chk("step", step, m_step);
    chk("load_full", load_full, (m_cnt == NB) ? 1 : 0);
`ifdef KEY_SCHED_PARITY_EN
    chk("key_err", key_err, m_err);
`endif
  endtask

  task automatic cyc(input bit l, input bit s, input bit c, input bit r);
    key_load   = l;
    key_sin    = s;
    key_commit = c;
    run        = r;
    @(posedge clock);
    m_clock(l, s, c, r);
    #1;
    check_outputs();
  endtask

  function automatic logic [63:0] key_word(input int s0, input int s1, input int s2,
                                           input int s3, input bit good);
    logic [63:0] v;
    int s[NK];
    s = '{s0, s1, s2, s3};
    v = '0;
    for (int k = 0; k < NK; k++) v[k*KW +: KW] = s[k][KW-1:0];
    if (PAR == 1) v[KB] = good ? ^v[KB-1:0] : ~^v[KB-1:0];
    return v;
  endfunction

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, v[i % 64], 1'b0, 1'b0);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Reset raised between edges must clear outputs with no clock edge.
  task automatic do_reset_async();
    key_load   = 1'b0;
    key_commit = 1'b0;
    run        = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_keyinput", keyinput, 0);
    chk("arst_key_valid", key_valid, 0);
    chk("arst_step", step, 0);
    chk("arst_load_full", load_full, 0);
    m_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [63:0] w;
    int seq[4];
    int n;
    int kind;

    m_reset();
    #2;
    chk("rst_keyinput", keyinput, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_step", step, 0);
    chk("rst_load_full", load_full, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_outputs();

    // Slots {5,2,7,1}, commit, then run through a full wrap.
    send_bits(key_word(5, 2, 7, 1, 1'b1), NB);
    chk("full_after_load", load_full, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("commit_keyinput", keyinput, 5);
    chk("commit_valid", key_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("run_first", keyinput, 5);
    seq = '{2, 7, 1, 5};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("run_seq", keyinput, seq[i]);
      chk("run_seq_valid", key_valid, 1);
    end

    // Pause at step 2 for three cycles, then resume.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("at_step2", step, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_step", step, 2);
      chk("hold_keyinput", keyinput, 7);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume_1", keyinput, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume_2", keyinput, 5);

    // Abort a run by loading {3,3,3,3}.
    w = key_word(3, 3, 3, 3, 1'b1);
    cyc(1'b1, w[0], 1'b0, 1'b0);
    chk("abort_valid", key_valid, 0);
    chk("abort_step", step, 0);
    chk("abort_keyinput", keyinput, 0);
    for (int i = 1; i < NB; i++) cyc(1'b1, w[i], 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("reload_keyinput", keyinput, 3);

    // Commit one bit short is ignored; completing the load then commits.
    w = key_word(6, 4, 1, 0, 1'b1);
    for (int i = 0; i < NB - 1; i++) cyc(1'b1, w[i], 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("short_valid", key_valid, 0);
    chk("short_keyinput", keyinput, 0);
    chk("short_full", load_full, 0);
    cyc(1'b1, w[NB-1], 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("late_commit", keyinput, 6);

    // Asynchronous reset mid-run, then load and commit together.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset_async();
    send_bits(key_word(2, 5, 3, 6, 1'b1), NB);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("load_wins_valid", key_valid, 0);
    chk("load_wins_full", load_full, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef KEY_SCHED_PARITY_EN
    do_reset_async();
    send_bits(key_word(5, 2, 7, 1, 1'b0), NB);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_bad_err", key_err, 1);
    chk("par_bad_valid", key_valid, 0);
    send_bits(key_word(4, 4, 4, 4, 1'b1), NB);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_good_valid", key_valid, 1);
    chk("par_good_keyinput", keyinput, 4);
    chk("par_err_sticky", key_err, 1);
`endif

    // Randomized phase.
    for (int seg = 0; seg < 200; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4) begin
        n = NB + $urandom_range(0, 3) - (($urandom_range(0, 4) == 0) ? 2 : 0);
        for (int i = 0; i < n; i++) cyc(1'b1, rb(), ($urandom_range(0, 7) == 0), 1'b0);
        if (rb()) cyc(1'b0, 1'b0, 1'b1, rb());
      end else if (kind <= 7) begin
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, ($urandom_range(0, 3) == 0), rb());
      end else if (kind == 8) begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) cyc(($urandom_range(0, 3) == 0), rb(), rb(), rb());
      end else if ($urandom_range(0, 3) == 0) begin
        do_reset_async();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_sched_feeder.md
KEY_SCHED_FEEDER -- requirements
Module: key_sched_feeder

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of time-varying key slots; the step counter is log2(NUM_KEYS) bits wide.
REQ-002 Parameter KEY_W, default 3: width of each key slot and of keyinput.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset; asynchronous and active-high.
REQ-005 key_sin  input  1  serial key bit, sampled while key_load is high.
REQ-006 key_load  input  1  shift enable for the serial key stream.
REQ-007 key_commit  input  1  request to copy the shadow key image into the active image.
REQ-008 run  input  1  advance enable; while high in RUN, the step counter increments every cycle.
REQ-009 keyinput  output  KEY_W  key presented to the downstream locked core.
REQ-010 key_valid  output  1  keyinput is from a committed image and matches the current step.
REQ-011 step  output  log2(NUM_KEYS)  mirrored core counter value.
REQ-012 load_full  output  1  shadow image holds NUM_KEYS*KEY_W bits.
REQ-013 key_err  output  1  sticky commit-rejection flag; present only with KEY_SCHED_PARITY_EN.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, READY and RUN.
REQ-015 IDLE->LOAD on key_load; LOAD->READY on accepted commit; READY->RUN on run; in any state, key_load->LOAD.
REQ-016 Loading: each key_load cycle, the shadow register SHALL shift right, with key_sin entering the MSB; bits arrive slot 0 first, each slot LSB first.
REQ-017 The bit counter SHALL saturate at NUM_KEYS*KEY_W; extra bits keep shifting, so the last NUM_KEYS*KEY_W bits are retained.
REQ-018 load_full SHALL be high once the bit counter has saturated, and SHALL clear on entry to LOAD from any state other than LOAD.
REQ-019 A commit SHALL be accepted only if key_commit=1, key_load=0 and load_full=1; otherwise it is ignored with no state change.
REQ-020 When key_load and key_commit are high together, the load SHALL win.
REQ-021 An accepted commit SHALL copy shadow to active in the same edge and reset step to 0.
REQ-022 keyinput SHALL be combinational from registers: active slot[step] when key_valid=1; otherwise all zeros.
REQ-023 key_valid SHALL be high exactly in READY and RUN.
REQ-024 In RUN with run=1, step SHALL increment by one per cycle and wrap from NUM_KEYS-1 to 0.
REQ-025 In RUN with run=0, step and keyinput SHALL hold.
REQ-026 key_load asserted in READY or RUN SHALL abort: key_valid=0 and step=0 from the next cycle; the active image is retained but is not presented until the next commit.

Reset
REQ-027 While reset is high: state=IDLE, step=0, bit counter=0, shadow=0, active=0, load_full=0, key_err=0, keyinput=0, key_valid=0.
REQ-028 Reset asserted mid-load or mid-run SHALL take effect immediately, without waiting for a clock edge.

Configuration
REQ-029 With macro KEY_SCHED_PARITY_EN defined, the stream SHALL carry one extra trailing even-parity bit; load_full then requires NUM_KEYS*KEY_W+1 bits.
REQ-030 With KEY_SCHED_PARITY_EN, a commit with bad parity SHALL be rejected, set key_err (cleared only by reset), and leave the FSM in LOAD.
REQ-031 Without KEY_SCHED_PARITY_EN, there SHALL be no parity bit and no key_err port.

Structure
REQ-032 The state enum, default NUM_KEYS/KEY_W and the step-width function SHALL reside in package key_sched_pkg.
REQ-033 The serial shadow register and its saturating bit counter SHALL form sub-module key_shift_reg; FSM, active image and step counter stay in the top.

Verification
REQ-034 After reset, drive 12 bits for slots {5,2,7,1} plus commit, then run=1 -> keyinput 5,2,7,1,5 on consecutive cycles; key_valid=1 throughout.
REQ-035 Commit after only 11 bits -> ignored: state stays LOAD, key_valid=0, keyinput=0.
REQ-036 In RUN at step=2, drop run for 3 cycles -> step=2 and keyinput=7 hold; resume run -> 1, then 5.
REQ-037 In RUN, assert key_load -> next cycle key_valid=0, step=0; reload {3,3,3,3} and commit -> keyinput=3.
REQ-038 Assert reset asynchronously mid-RUN -> all outputs 0 immediately; simultaneous key_load and key_commit -> a shift occurs and no commit.
REQ-039 With KEY_SCHED_PARITY_EN, send a wrong parity bit and commit -> key_err=1, key_valid=0; correct parity -> commit accepted.
